// File: rtl/vip_frame_ctrl.sv
// Frame-sequencing controller for the VIP chain: admits whole frames only,
// latches the binarization threshold per frame and checks frame geometry.
module vip_frame_ctrl #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter logic [7:0]  THR_RST   = 8'd150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic        start,
  input  logic        cont_mode,
  input  logic        abort,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_threshold,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [7:0]  active_threshold,
  output logic        busy,
  output logic        frame_done,
  output logic        size_err,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [10:0] CNT_MAX = 11'h7FF;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        vsync_r;
  logic        href_r;
  logic        rise;
  logic        fall;
  logic        line_end;
  logic        pixel;
  logic        accept;
  logic        pass;
  logic        frame_end;
  logic        line_bad;
  logic [7:0]  pend_thr;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] v_cnt_fin;
  logic        err_acc;

  assign rise      = per_frame_vsync & ~vsync_r;
  assign fall      = ~per_frame_vsync & vsync_r;
  assign line_end  = ~per_frame_href & href_r;
  assign pixel     = per_frame_href & per_frame_clken;
  assign accept    = (state == ST_ARM) & rise & ~abort;
  assign pass      = ((state == ST_RUN) & ~abort) | accept;
  assign frame_end = (state == ST_RUN) & fall & ~abort;

  // A line ending in the same cycle as vsync falls still has to be judged,
  // so the end-of-frame verdict uses the post-line-end view of the counters.
  assign line_bad  = line_end & (h_cnt != IMG_HDISP);
  assign v_cnt_fin = (line_end && (v_cnt != CNT_MAX)) ? v_cnt + 11'd1 : v_cnt;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = ST_ARM;
        ST_ARM:  if (rise)  state_nxt = ST_RUN;
        ST_RUN:  if (fall)  state_nxt = cont_mode ? ST_ARM : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != ST_IDLE);
      vsync_r <= per_frame_vsync;
      href_r  <= per_frame_href;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync & pass;
      post_frame_href  <= per_frame_href  & pass;
      post_frame_clken <= per_frame_clken & pass;
    end
  end

  // A write landing on the admitting rise must win over the stale pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_thr         <= THR_RST;
      active_threshold <= THR_RST;
    end else begin
      if (cfg_we) pend_thr <= cfg_threshold;
      if (accept) active_threshold <= cfg_we ? cfg_threshold : pend_thr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt   <= 11'd0;
      v_cnt   <= 11'd0;
      err_acc <= 1'b0;
    end else if (accept) begin
      h_cnt   <= {10'd0, pixel};
      v_cnt   <= 11'd0;
      err_acc <= 1'b0;
    end else if (pass) begin
      if (line_end) begin
        h_cnt <= 11'd0;
        v_cnt <= v_cnt_fin;
        if (line_bad) err_acc <= 1'b1;
      end else if (pixel && (h_cnt != CNT_MAX)) begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      size_err   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        size_err  <= err_acc | line_bad | (v_cnt_fin != IMG_VDISP);
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/vip_frame_ctrl.md
# vip_frame_ctrl

Frame-sequencing controller between the camera-timing source (or the RGB888→YCbCr444 stage) and the downstream VIP processing chain (binarization / connected-component top). It admits whole frames only, either single-shot on `start` or continuously. It holds the binarization threshold stable for the duration of each frame. It checks every admitted frame against the expected geometry and reports completion and size errors.

## Interface
Parameters:
- `IMG_HDISP`, 640, expected active pixels per line (11-bit).
- `IMG_VDISP`, 480, expected active lines per frame (11-bit).
- `THR_RST`, 150, reset value of both threshold registers.

Ports:
- `clk`  in  1  system clock (50 MHz); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `per_frame_vsync`  in  1  input vsync; high = frame valid, low = sync.
- `per_frame_href`  in  1  input line-valid.
- `per_frame_clken`  in  1  input pixel enable.
- `start`  in  1  one-cycle request to capture one frame, or to begin continuous mode.
- `cont_mode`  in  1  1 = re-arm after each frame; sampled at frame end.
- `abort`  in  1  one-cycle request to stop immediately.
- `cfg_we`  in  1  write strobe for `cfg_threshold`.
- `cfg_threshold`  in  8  pending binarization threshold.
- `post_frame_vsync`  out  1  gated vsync.
- `post_frame_href`  out  1  gated href.
- `post_frame_clken`  out  1  gated clken.
- `active_threshold`  out  8  threshold for the frame in flight.
- `busy`  out  1  high in ARM or RUN.
- `frame_done`  out  1  one-cycle pulse at the end of an admitted frame.
- `size_err`  out  1  geometry mismatch in the last completed frame.
- `frame_cnt`  out  16  count of completed frames; wraps.

## Operation
- Internal `vsync_r` and `href_r` hold the previous-cycle inputs.
  - rise = `per_frame_vsync & ~vsync_r`; fall = `~per_frame_vsync & vsync_r`.
  - line end = `~per_frame_href & href_r`.
- States:
  - IDLE: `start` → ARM.
  - ARM: rise → RUN. A frame already in progress when ARM is entered is never admitted (partial frames are never passed).
  - RUN: fall → `cont_mode` ? ARM : IDLE, with `frame_done` asserted.
- `abort` in any state → IDLE. `abort` has priority over `start` and over any edge in the same cycle. An aborted frame gives no `frame_done`, no `frame_cnt` increment and no `size_err` update.
- `start` in ARM or RUN is ignored.
- pass = (state==RUN & ~abort) | (state==ARM & rise & ~abort).
- Threshold:
  - `pend_thr` is written on `cfg_we`.
  - `active_threshold` loads `pend_thr` on the accepted rise (ARM→RUN). If `cfg_we` and the accepted rise fall in the same cycle, the new `cfg_threshold` value is used.
- Geometry check, only while pass:
  - `h_cnt` (11 b) counts `per_frame_href & per_frame_clken`, saturating at 2047.
  - At line end: `h_cnt != IMG_HDISP` sets `err_acc`; `v_cnt` increments (saturating); `h_cnt` clears.
  - At fall: `v_cnt != IMG_VDISP` also counts as an error.
  - `size_err` <= `err_acc` | that vertical check, and `frame_cnt` increments.
  - `h_cnt`, `v_cnt` and `err_acc` clear on the accepted rise.

## Timing
- Reset values:
  - all `post_*`, `busy`, `frame_done` and `size_err` = 0;
  - `frame_cnt` = 0;
  - `active_threshold` = `pend_thr` = `THR_RST`;
  - state = IDLE.
- Data path: `post_x` <= `per_x` & pass, registered, giving a fixed 1-cycle latency. `post_frame_vsync` first goes high the cycle after the input rise.
- Frame end:
  - `frame_done`, `size_err` and `frame_cnt` update on the clock edge after the cycle in which fall is seen.
  - `post_frame_vsync` goes low on that same edge.
- `busy` is a registered decode of the next state. It rises 1 cycle after `start` and falls together with `frame_done`.
- Abort in RUN: all `post_*` are 0 from the next edge onward. Outputs may truncate mid-line; downstream resynchronises on vsync.
- Continuous mode: back-to-back frames need no gap beyond the source's vsync-low period. The fall and the next rise are at least 1 cycle apart by construction.
- Reset mid-frame clears everything asynchronously; the outputs drop in the same instant.

## Test plan
Default geometry for all tests except 6: `IMG_HDISP`=8, `IMG_VDISP`=4, with the source driving exactly 8 clken pulses per line and 4 lines per frame.

1. `start` pulse mid-frame, `cont_mode`=0 → the partial frame is blocked. The next full frame passes with 1-cycle delay, 32 `post_frame_clken` pulses, `frame_done`=1 for one cycle, `frame_cnt`=1, `size_err`=0, then IDLE with no further output.
2. `cont_mode`=1, 3 frames → 3 `frame_done` pulses, `frame_cnt`=3, no gap in admitted frames. Drop `cont_mode` during the 3rd frame → IDLE after the 3rd frame.
3. `cfg_threshold`=200 written mid-frame with `active_threshold`=150 → value stays 150 until the next accepted rise, then becomes 200. A write coincident with the rise takes effect at that rise.
4. Source sends one line of 7 pixels → `size_err`=1 at `frame_done`. The following correct frame clears it to 0. A 5-line frame also gives `size_err`=1.
5. `abort` asserted in RUN at line 2 → `post_*` at 0 the next cycle, no `frame_done`, `frame_cnt` unchanged, `busy`=0. `abort` together with `start` in IDLE → stays IDLE.
6. `IMG_HDISP`=640, `IMG_VDISP`=480 with the half-rate clken camera model; assert `rst_n` low mid-frame → all outputs 0 immediately. After release, a `start` captures a full 640×480 frame with `size_err`=0 and 307200 `post_frame_clken` pulses.
